// File: rtl/weight_stream_pkg.sv
// Shared word and sizing definitions for the weight/activation stream path.
// Consumed by the stream buffer, the streamer and the MVTU compute array.
package weight_stream_pkg;

    localparam int unsigned WEIGHT_LEVELS = 2;
    localparam int unsigned SIMD_WIDTH    = 32;
    localparam int unsigned W             = SIMD_WIDTH * WEIGHT_LEVELS;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_AF_THRESH = 3;
    localparam int unsigned PTR_W         = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W         = PTR_W + 1;

    // One SIMD word: simd_width lanes of weight_levels bits each.
    typedef logic [W-1:0] word_t;

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from storage)
module buffer_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_stream_buffer.sv
// Elastic first-word-fall-through buffer between the weight/activation
// streamer and the MVTU array. Valid/ready on both sides, synchronous flush,
// occupancy count and almost-full flag. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         synchronous clear of occupancy and pointers
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake (out_data zero when empty)
//   count         occupancy 0..DEPTH
//   almost_full   count >= AF_THRESH
module weight_stream_buffer
    import weight_stream_pkg::*;
#(
    parameter int unsigned weight_levels = WEIGHT_LEVELS,
    parameter int unsigned simd_width    = SIMD_WIDTH,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned AF_THRESH     = DEF_AF_THRESH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    input  logic [simd_width*weight_levels-1:0]   in_data,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [simd_width*weight_levels-1:0]   out_data,
    input  logic                                  out_ready,
    output logic [$clog2(DEPTH):0]                count,
    output logic                                  almost_full
);

    localparam int unsigned DATA_W = simd_width * weight_levels;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              almost_full_q, almost_full_d;
    logic              push_c, pop_c, ram_we_c;
    logic [DATA_W-1:0] ram_rdata;

    // Next-state: flush dominates any same-cycle push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_c   = in_valid && in_ready_q;
        pop_c    = out_valid_q && out_ready;
        ram_we_c = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            ram_we_c = push_c;
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Status flags are precomputed so they come straight from flops
        in_ready_d    = (count_d != CW'(DEPTH));
        out_valid_d   = (count_d != '0);
        almost_full_d = (count_d >= CW'(AF_THRESH));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
        end
    end

    buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign count       = count_q;
    assign almost_full = almost_full_q;
    // Stale storage never leaks out when the buffer is empty
    assign out_data    = out_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_weight_stream_buffer.sv
module tb_weight_stream_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic        almost_full;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    weight_stream_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    // Protocol invariants sampled on every active edge
    always @(posedge clk) begin
        if (rst === 1'b0 && flush === 1'b0) begin
            checks++;
            if (count > 3'd4) begin
                errors++;
                $display("FAIL inv_count_max: count=%0d required<=4", count);
            end
            if (out_valid && out_ready && count == 3'd0) begin
                errors++;
                $display("FAIL inv_pop_empty: pop with count=0");
            end
            if (in_valid && in_ready && count == 3'd4) begin
                errors++;
                $display("FAIL inv_push_full: push with count=4");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 ||
                almost_full !== 1'b0 || out_data !== 64'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: ov=%b ir=%b cnt=%0d af=%b od=%h required ov=0 ir=1 cnt=0 af=0 od=0",
                         c, out_valid, in_ready, count, almost_full, out_data);
            end
            tick();
        end
    endtask

    task automatic test_fill();
        logic [63:0] w [4];
        w[0] = 64'hAAAA_AAAA_AAAA_AAA1;
        w[1] = 64'hAAAA_AAAA_AAAA_AAA2;
        w[2] = 64'hAAAA_AAAA_AAAA_AAA3;
        w[3] = 64'hAAAA_AAAA_AAAA_AAA4;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = w[i];
            tick();
            checks++;
            if (count !== 3'(i + 1) || out_valid !== 1'b1 || out_data !== w[0] ||
                almost_full !== (i + 1 >= 3) || in_ready !== (i + 1 != 4)) begin
                errors++;
                $display("FAIL fill[%0d]: cnt=%0d ov=%b od=%h af=%b ir=%b required cnt=%0d od=%h af=%b ir=%b",
                         i, count, out_valid, out_data, almost_full, in_ready,
                         i + 1, w[0], (i + 1 >= 3), (i + 1 != 4));
            end
        end
        in_data = 64'hBBBB_BBBB_BBBB_BBBB;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 3'd4 || in_ready !== 1'b0 || out_data !== w[0]) begin
                errors++;
                $display("FAIL full_hold[%0d]: cnt=%0d ir=%b od=%h required cnt=4 ir=0 od=%h",
                         i, count, in_ready, out_data, w[0]);
            end
        end
    endtask

    task automatic test_drain();
        logic [63:0] e [5];
        logic [2:0]  ec [5];
        e[0] = 64'hAAAA_AAAA_AAAA_AAA1; ec[0] = 3'd4;
        e[1] = 64'hAAAA_AAAA_AAAA_AAA2; ec[1] = 3'd3;
        e[2] = 64'hAAAA_AAAA_AAAA_AAA3; ec[2] = 3'd3;
        e[3] = 64'hAAAA_AAAA_AAAA_AAA4; ec[3] = 3'd2;
        e[4] = 64'hBBBB_BBBB_BBBB_BBBB; ec[4] = 3'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== e[i] || count !== ec[i]) begin
                errors++;
                $display("FAIL drain[%0d]: ov=%b od=%h cnt=%0d required ov=1 od=%h cnt=%0d",
                         i, out_valid, out_data, count, e[i], ec[i]);
            end
            tick();
            // BB is accepted at the second edge, when a slot first frees up
            if (i == 1) in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL drain_empty: ov=%b cnt=%0d od=%h required ov=0 cnt=0 od=0",
                     out_valid, count, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            in_data = 64'(k);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(k) || count !== 3'd1) begin
                errors++;
                $display("FAIL stream[%0d]: ov=%b od=%h cnt=%0d required ov=1 od=%h cnt=1",
                         k, out_valid, out_data, count, 64'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL stream_end: ov=%b cnt=%0d required ov=0 cnt=0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 64'hC1; tick();
        in_data = 64'hC2; tick();
        in_data = 64'hC3; tick();
        checks++;
        if (count !== 3'd3 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: cnt=%0d af=%b required cnt=3 af=1", count, almost_full);
        end
        flush = 1'b1; in_data = 64'hC4; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            almost_full !== 1'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL flush_clear: cnt=%0d ov=%b ir=%b af=%b od=%h required cnt=0 ov=0 ir=1 af=0 od=0",
                     count, out_valid, in_ready, almost_full, out_data);
        end
        in_valid = 1'b1; in_data = 64'hD1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hD1 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_next: ov=%b od=%h cnt=%0d required ov=1 od=d1 cnt=1",
                     out_valid, out_data, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data = 64'hE1; tick();
        in_data = 64'hE2; tick();
        checks++;
        if (count !== 3'd2 || out_data !== 64'hE1) begin
            errors++;
            $display("FAIL rmid_pre: cnt=%0d od=%h required cnt=2 od=e1", count, out_data);
        end
        rst = 1'b1; in_data = 64'hE3;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0) begin
                errors++;
                $display("FAIL rmid_clear[%0d]: cnt=%0d ov=%b ir=%b od=%h required cnt=0 ov=0 ir=1 od=0",
                         c, count, out_valid, in_ready, out_data);
            end
            tick();
        end
        in_valid = 1'b1; in_data = 64'hF1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hF1 || count !== 3'd1) begin
            errors++;
            $display("FAIL rmid_next: ov=%b od=%h cnt=%0d required ov=1 od=f1 cnt=1",
                     out_valid, out_data, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
